moore_seq_detector: RTL and testbench

Parametrised Moore-style serial sequence detector and the successor to the fixed five-state detector. It watches a gated serial bit stream for a run-time programmable pattern of `PAT_LEN` bits. It supports overlapping and non-overlapping match modes and keeps an optional saturating match counter. The detector sits between a serial front end and a control/status block. Its output depends only on the current state.

---
 rtl/moore_seq_detector.sv | 170 +++++++++++++++++
 tb/tb_moore_seq_detector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector.sv
// ---------------------------------------------------------------------------
// moore_seq_detector
//
// Moore-style serial sequence detector. It watches a gated serial bit stream
// for a run-time programmable pattern of PAT_LEN bits. It supports
// overlapping and non-overlapping match modes. The output depends only on
// the current state.
//
// Parameters
//   PAT_LEN   : pattern length in bits (2..16)
//   CNT_W     : match counter width (1..32)
//
// Ports
//   clk       : clock, rising-edge active
//   reset     : asynchronous, active-low reset
//   pat_load  : capture 'pattern' and restart detection (highest priority)
//   pattern   : target sequence; bit PAT_LEN-1 is the oldest bit expected
//   bin_valid : qualifies 'bin'
//   bin       : serial data input
//   overlap   : 1 = overlapping matches, 0 = non-overlapping
//   bout      : high exactly while in S_MATCH
//   hit_count : saturating count of matches since the last load
//
// Configuration macro: MOORE_SEQ_DET_COUNT_EN
//   defined   -> saturating match counter is built
//   undefined -> no counter register, hit_count tied to 0
// ---------------------------------------------------------------------------
module moore_seq_detector #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               bin_valid,
  input  logic               bin,
  input  logic               overlap,
  output logic               bout,
  output logic [CNT_W-1:0]   hit_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_HUNT  = 2'd2;
  localparam logic [1:0] S_MATCH = 2'd3;

  // Fill counter must be able to hold the value PAT_LEN itself.
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [1:0]         r_state;
  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;

  logic [1:0]         w_stateNext;
  logic [PAT_LEN-1:0] w_histNext;
  logic [FILL_W-1:0]  w_fillNext;
  logic [PAT_LEN-1:0] w_histShift;
  logic [FILL_W-1:0]  w_fillInc;
  logic               w_hit;

  assign w_histShift = {r_hist[PAT_LEN-2:0], bin};
  assign w_fillInc   = r_fill + FILL_W'(1);
  assign w_hit       = (w_histShift == r_pat);

  // Next-state and datapath decode. pat_load overrides every state, and a
  // non-overlapping exit from S_MATCH discards the matched bits so they can
  // never be part of the next match.
  always_comb begin
    w_stateNext = r_state;
    w_histNext  = r_hist;
    w_fillNext  = r_fill;
    if (pat_load) begin
      w_stateNext = S_FILL;
      w_histNext  = '0;
      w_fillNext  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_stateNext = S_IDLE;
        end
        S_FILL: begin
          if (bin_valid) begin
            w_histNext = w_histShift;
            w_fillNext = w_fillInc;
            if (w_fillInc == FILL_FULL) begin
              w_stateNext = w_hit ? S_MATCH : S_HUNT;
            end
          end
        end
        S_HUNT: begin
          if (bin_valid) begin
            w_histNext = w_histShift;
            if (w_hit) begin
              w_stateNext = S_MATCH;
            end
          end
        end
        S_MATCH: begin
          if (overlap) begin
            if (bin_valid) begin
              w_histNext  = w_histShift;
              w_stateNext = w_hit ? S_MATCH : S_HUNT;
            end else begin
              w_stateNext = S_HUNT;
            end
          end else begin
            w_stateNext = S_FILL;
            if (bin_valid) begin
              w_histNext = {{(PAT_LEN-1){1'b0}}, bin};
              w_fillNext = FILL_W'(1);
            end else begin
              w_histNext = '0;
              w_fillNext = '0;
            end
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // State, pattern, history and fill registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_hist  <= w_histNext;
      r_fill  <= w_fillNext;
      if (pat_load) begin
        r_pat <= pattern;
      end
    end
  end

  assign bout = (r_state == S_MATCH);

`ifdef MOORE_SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_hitCount;
  logic             w_matchEvt;

  // Entering or staying in S_MATCH only ever happens on a hit, and pat_load
  // always forces S_FILL, so landing in S_MATCH is exactly one match.
  assign w_matchEvt = (w_stateNext == S_MATCH);

  // Saturating match counter, cleared by every pattern load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hitCount <= '0;
    end else if (pat_load) begin
      r_hitCount <= '0;
    end else if (w_matchEvt && (r_hitCount != {CNT_W{1'b1}})) begin
      r_hitCount <= r_hitCount + CNT_W'(1);
    end
  end

  assign hit_count = r_hitCount;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detector
//
// Self-checking bench for moore_seq_detector. A reference model keeps the
// valid bits seen since the last restart in a queue and declares a match
// whenever the newest PAT_LEN bits equal the loaded pattern.
// Expected hit_count follows MOORE_SEQ_DET_COUNT_EN (0 when undefined).
// ---------------------------------------------------------------------------
module tb_moore_seq_detector;

  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               reset;
  logic               pat_load;
  logic [PAT_LEN-1:0] pattern;
  logic               bin_valid;
  logic               bin;
  logic               overlap;
  logic               bout;
  logic [CNT_W-1:0]   hit_count;

  int nCompared;
  int nMismatched;

  // Reference model state
  logic               mLoaded;
  logic [PAT_LEN-1:0] mPat;
  int                 mBits[$];
  logic               mMatch;
  int                 mCount;

  string sect;

  moore_seq_detector #(
    .PAT_LEN(PAT_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pat_load (pat_load),
    .pattern  (pattern),
    .bin_valid(bin_valid),
    .bin      (bin),
    .overlap  (overlap),
    .bout     (bout),
    .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter value the DUT should present for a given number of matches.
  function automatic int expCount(input int n);
`ifdef MOORE_SEQ_DET_COUNT_EN
    return (n > CNT_MAX) ? CNT_MAX : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLoaded = 1'b0;
    mPat    = '0;
    mBits.delete();
    mMatch  = 1'b0;
    mCount  = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic modelStep(input logic pl, input logic [PAT_LEN-1:0] pat,
                           input logic v, input logic b, input logic ov);
    int tail;
    if (pl) begin
      mPat    = pat;
      mBits.delete();
      mCount  = 0;
      mMatch  = 1'b0;
      mLoaded = 1'b1;
    end else if (mLoaded) begin
      if (mMatch && !ov) begin
        mBits.delete();
        if (v) mBits.push_back(int'(b));
        mMatch = 1'b0;
      end else if (v) begin
        mBits.push_back(int'(b));
        if (mBits.size() > PAT_LEN) void'(mBits.pop_front());
        tail = 0;
        foreach (mBits[i]) tail = tail * 2 + mBits[i];
        mMatch = (mBits.size() == PAT_LEN) && (tail == int'(mPat));
        if (mMatch && mCount < CNT_MAX) mCount++;
      end else begin
        mMatch = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model and check both outputs.
  task automatic applyStimulus(input logic pl, input logic [PAT_LEN-1:0] pat,
                               input logic v, input logic b, input logic ov);
    @(negedge clk);
    pat_load  = pl;
    pattern   = pat;
    bin_valid = v;
    bin       = b;
    overlap   = ov;
    @(posedge clk);
    modelStep(pl, pat, v, b, ov);
    #1;
    checkOutput({sect, ".bout"}, 32'(bout), 32'(mMatch));
    checkOutput({sect, ".count"}, 32'(hit_count), 32'(expCount(mCount)));
  endtask

  task automatic feedBits(input logic [PAT_LEN-1:0] pat, input int n,
                          input logic [15:0] bits, input logic ov);
    logic [15:0] bv;
    bv = bits;
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b0, pat, 1'b1, bv[i], ov);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    pat_load    = 1'b0;
    pattern     = '0;
    bin_valid   = 1'b0;
    bin         = 1'b0;
    overlap     = 1'b1;
    reset       = 1'b0;
    modelReset();
    #1;
    checkOutput("rst.bout", 32'(bout), 32'd0);
    checkOutput("rst.count", 32'(hit_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Overlapping 1011 on 1,0,1,1,0,1,1
    sect = "ovl1011";
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    feedBits(4'b1011, 7, 16'b1011011, 1'b1);
    checkOutput("ovl1011.total", 32'(hit_count), 32'(expCount(2)));

    // Non-overlapping, same stream
    sect = "nov1011";
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
    feedBits(4'b1011, 7, 16'b1011011, 1'b0);
    checkOutput("nov1011.total", 32'(hit_count), 32'(expCount(1)));

    // 1111 with six ones, overlapping: three back-to-back matches
    sect = "ovl1111";
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    feedBits(4'b1111, 6, 16'b111111, 1'b1);
    checkOutput("ovl1111.total", 32'(hit_count), 32'(expCount(3)));

    // 1111 with eight ones, non-overlapping: pulses after bits 4 and 8
    sect = "nov1111";
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    feedBits(4'b1111, 8, 16'b11111111, 1'b0);
    checkOutput("nov1111.total", 32'(hit_count), 32'(expCount(2)));

    // Gated stream: two invalid cycles with random data between each bit
    sect = "gated";
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] gb;
      gb = 4'b1011;
      applyStimulus(1'b0, 4'b1011, 1'b1, gb[i], 1'b1);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'($urandom), 1'b1);
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'($urandom), 1'b1);
    end
    checkOutput("gated.total", 32'(hit_count), 32'(expCount(1)));

    // Saturation: twelve ones on 1111 overlapping gives nine matches
    sect = "sat";
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    feedBits(4'b1111, 12, 16'hFFF, 1'b1);
    checkOutput("sat.total", 32'(hit_count), 32'(expCount(9)));

    // Load on the edge that would complete a match wins
    sect = "loadwin";
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    feedBits(4'b1011, 3, 16'b101, 1'b1);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1);
    checkOutput("loadwin.count", 32'(hit_count), 32'd0);
    checkOutput("loadwin.bout", 32'(bout), 32'd0);

    // Async reset while hunting, then no match without a new load
    sect = "arst";
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    feedBits(4'b1011, 5, 16'b10110, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.bout", 32'(bout), 32'd0);
    checkOutput("arst.count", 32'(hit_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    feedBits(4'b1011, 4, 16'b1011, 1'b1);
    checkOutput("arst.nomatch", 32'(bout), 32'd0);

    // Randomized traffic with occasional reloads
    sect = "rand";
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0) || (i == 0),
                    PAT_LEN'($urandom), ($urandom_range(0, 3) != 0),
                    1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
